sound_out_buffer: RTL and testbench
===================================

SOUND_OUT_BUFFER -- requirements
Module: sound_out_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 32-bit stereo samples, power of two, at least 8.
REQ-002 Parameter LOW_WATER, default 4, fill level at or below which a refill burst is requested.
REQ-003 Parameter BURST, default 8, samples per NeXT sound-out refill burst, at most DEPTH-LOW_WATER.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  sound-out stream enable from NeXT control register.
REQ-007 wr_valid  input  1  sample word from NeXT sound-out decode is present.
REQ-008 wr_data  input  32  sample word: [31:16] left, [15:0] right.
REQ-009 wr_ready  output  1  buffer accepts wr_data this cycle.
REQ-010 out_valid  output  1  out_data holds a sample for the I2S sender.
REQ-011 out_data  output  32  head-of-FIFO sample.
REQ-012 out_ready  input  1  I2S sender takes out_data this cycle.
REQ-013 req  output  1  level request to NeXT hardware for a refill burst.
REQ-014 level  output  $clog2(DEPTH)+1  current fill count.
REQ-015 underrun  output  1  sticky underrun flag.
REQ-016 clr_underrun  input  1  clears underrun.

Function
REQ-017 A write is accepted when wr_valid && wr_ready; a read is accepted when out_valid && out_ready.
REQ-018 wr_ready is registered: it is high iff enable is high and level < DEPTH at the previous edge, so a full FIFO rejects a write even if a read occurs in the same cycle.
REQ-019 out_valid is high iff level != 0; out_data is the head word (first-word-fall-through); write-to-out_valid latency is 1 cycle from an empty FIFO.
REQ-020 A simultaneous accepted read and write leaves level unchanged; pointers wrap modulo DEPTH.
REQ-021 The refill FSM has states IDLE, REQUEST and RECEIVE; req is high only in REQUEST.
REQ-022 IDLE -> REQUEST when enable && level <= LOW_WATER.
REQ-023 REQUEST -> RECEIVE on the first accepted write; a burst counter is loaded with BURST-1.
REQ-024 RECEIVE decrements the counter on each accepted write and goes -> IDLE on the accept that occurs when the counter is 0.
REQ-025 Writes accepted in IDLE (unsolicited) are stored and do not affect the FSM.
REQ-026 On an enable low cycle: pointers clear, level=0, FSM -> IDLE, req=0, and wr_ready=0 on the next cycle; underrun is preserved.
REQ-027 underrun sets when enable && out_ready && level==0, including the cycle after the last sample is drained.
REQ-028 clr_underrun clears underrun; when set and clear occur in the same cycle, set wins.
REQ-029 out_valid never asserts while enable is low.

Reset
REQ-030 While rst is high: pointers=0, level=0, FSM=IDLE, burst counter=0, wr_ready=0, out_valid=0, out_data=0, req=0, underrun=0; FIFO RAM contents are not reset.
REQ-031 A reset mid-burst abandons the burst; req stays low until REQ-022 holds after rst falls.

Structure
REQ-032 Package sound_pkg holds SAMPLE_W=32, the refill FSM state enum and the default DEPTH, LOW_WATER and BURST constants.
REQ-033 Storage is one sub-module, sample_fifo (dual-pointer RAM, DEPTH x SAMPLE_W, synchronous write, asynchronous read); the FSM, level and flags live in sound_out_buffer.

Verification
REQ-034 Reset then enable=1 -> req=1 on the 2nd cycle; feed 8 words 0x00010001..0x00080008 -> req drops after the 1st accept, FSM returns to IDLE after the 8th, level=8.
REQ-035 Fill to 16 with out_ready=0 -> wr_ready=0; assert wr_valid and out_ready together -> read accepted, write rejected, level=15; next cycle wr_ready=1.
REQ-036 Empty FIFO, write 0xDEADBEEF -> out_valid=1 next cycle with out_data=0xDEADBEEF; out_ready=1 -> level=0 and out_valid=0 the next cycle.
REQ-037 Drain with out_ready held one extra cycle -> underrun=1; clr_underrun pulse -> underrun=0; clr_underrun coincident with a new underrun -> underrun stays 1.
REQ-038 Mid-burst (3 of 8 received) drop enable for 1 cycle -> level=0, req=0, FSM=IDLE; re-enable -> new request and a full 8-word burst counted.
REQ-039 Assert rst asynchronously mid-RECEIVE -> all outputs are at their reset values before the next clk edge.

Source files
------------

// File: rtl/sound_out_buffer_pkg.sv
// Shared constants and types for the NeXT sound-out sample buffer.
package sound_pkg;

    localparam int SAMPLE_W      = 32;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_LOW_WATER = 4;
    localparam int DEF_BURST     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RECEIVE = 2'd2
    } refill_state_t;

endpackage

// File: rtl/sound_out_buffer_if.sv
// Sample write side and I2S read side handshakes of the sound-out buffer.
interface sound_out_buffer_if;
    import sound_pkg::*;

    logic                wr_valid;
    logic [SAMPLE_W-1:0] wr_data;
    logic                wr_ready;
    logic                out_valid;
    logic [SAMPLE_W-1:0] out_data;
    logic                out_ready;

    modport master (
        output wr_valid, wr_data, out_ready,
        input  wr_ready, out_valid, out_data
    );

    modport slave (
        input  wr_valid, wr_data, out_ready,
        output wr_ready, out_valid, out_data
    );

endinterface

// File: rtl/sound_out_buffer_fifo.sv
// Sample storage: dual-pointer RAM with synchronous write and
// asynchronous (fall-through) read of the word at the read pointer.
module sample_fifo
    import sound_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    output logic [SAMPLE_W-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    // Pointers advance on accepted transfers and wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // RAM contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sound_out_buffer.sv
// Sound-out sample buffer: FIFO between NeXT sound-out decode and the I2S
// sender, with a refill-request FSM and a sticky underrun flag.
module sound_out_buffer
    import sound_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LOW_WATER = DEF_LOW_WATER,
    parameter int BURST     = DEF_BURST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    sound_out_buffer_if.slave      bus,
    output logic                   req,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun,
    input  logic                   clr_underrun
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(BURST) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] LOW_LEVEL  = LW'(LOW_WATER);
    localparam logic [CW-1:0] BURST_LOAD = CW'(BURST - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    refill_state_t       state;
    logic [CW-1:0]       burst_cnt;
    logic                wr_ready_q;
    logic                wr_acc;
    logic                rd_acc;
    logic [LW-1:0]       level_next;
    logic [SAMPLE_W-1:0] head;

    assign wr_acc        = bus.wr_valid && wr_ready_q;
    assign rd_acc        = bus.out_valid && bus.out_ready;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.out_valid = enable && (level != '0);
    assign bus.out_data  = bus.out_valid ? head : '0;

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (!enable),
        .wr_en   (wr_acc),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc),
        .rd_data (head)
    );

    // Fill count after this cycle's transfers; a simultaneous read and write cancel out.
    always_comb begin
        level_next = level;
        if (wr_acc && !rd_acc)      level_next = level + 1'b1;
        else if (rd_acc && !wr_acc) level_next = level - 1'b1;
    end

    // Level and registered wr_ready, so a full buffer refuses writes even while being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= '0;
            wr_ready_q <= 1'b0;
        end else if (!enable) begin
            level      <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            level      <= level_next;
            wr_ready_q <= (level_next < FULL_LEVEL);
        end
    end

    // Refill FSM; burst_cnt holds the words still owed after the one being accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            req       <= 1'b0;
        end else if (!enable) begin
            state     <= IDLE;
            burst_cnt <= '0;
            req       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (level <= LOW_LEVEL) begin
                        state <= REQUEST;
                        req   <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (wr_acc) begin
                        req       <= 1'b0;
                        burst_cnt <= BURST_LOAD;
                        if (BURST == 1) state <= IDLE;
                        else            state <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (wr_acc) begin
                        if (burst_cnt <= CNT_ONE) begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                    req       <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun: the sender asked for data from an empty buffer; a new set beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (enable && bus.out_ready && (level == '0)) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sound_out_buffer.sv
// Directed scoreboard bench for sound_out_buffer (DEPTH=16, LOW_WATER=4, BURST=8).
module tb_sound_out_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        req;
    logic [4:0]  level;
    logic        underrun;
    logic        clr_underrun;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [31:0] exp_q[$];

    sound_out_buffer_if bus();

    sound_out_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .bus          (bus),
        .req          (req),
        .level        (level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic ordy,
                                 input logic en, input logic clr, input logic accept);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.out_ready = ordy;
        enable       = en;
        clr_underrun = clr;
        if (accept) exp_q.push_back(wd);
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    // Monitor: every accepted read must return the oldest word the bench expects.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL pop_empty: got 0x%08h, expected no read at %0t", bus.out_data, $time);
            end else begin
                checkOutput("out_data_pop", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // Runaway guard.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data",  bus.out_data,       32'd0);
        checkOutput("rst_req",       32'(req),           32'd0);
        checkOutput("rst_level",     32'(level),         32'd0);
        checkOutput("rst_underrun",  32'(underrun),      32'd0);
        rst = 1'b0;

        // Enable, then a first 8-word requested burst.
        nextCycle(); idleInputs(); midCycle();
        checkOutput("en_req_c1", 32'(req), 32'd0);
        checkOutput("en_wr_ready_c1", 32'(bus.wr_ready), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            applyStimulus(1'b1, {16'(i), 16'(i)}, 1'b0, 1'b1, 1'b0, 1'b1);
            midCycle();
            checkOutput("burst1_wr_ready", 32'(bus.wr_ready), 32'd1);
            checkOutput("burst1_req", 32'(req), (i == 1) ? 32'd1 : 32'd0);
        end
        nextCycle(); idleInputs(); midCycle();
        checkOutput("burst1_level", 32'(level), 32'd8);
        checkOutput("burst1_req_low", 32'(req), 32'd0);
        checkOutput("burst1_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("burst1_head", bus.out_data, 32'h0001_0001);

        // Drain to the low-water mark; the FSM must be back in IDLE to re-request.
        for (int j = 0; j < 4; j++) begin
            nextCycle();
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        nextCycle(); idleInputs(); midCycle();
        checkOutput("low_level", 32'(level), 32'd4);
        checkOutput("low_req_pending", 32'(req), 32'd0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("low_req", 32'(req), 32'd1);

        // Fill to full: 8-word burst plus 4 unsolicited words.
        for (int i = 1; i <= 12; i++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h0100_0000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1);
            midCycle();
            checkOutput("fill_wr_ready", 32'(bus.wr_ready), 32'd1);
        end
        nextCycle(); idleInputs(); midCycle();
        checkOutput("full_level", 32'(level), 32'd16);
        checkOutput("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("full_req", 32'(req), 32'd0);

        // Read and write together while full: only the read is taken.
        nextCycle();
        applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 1'b0, 1'b0);
        midCycle();
        checkOutput("full_rw_wr_ready", 32'(bus.wr_ready), 32'd0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("full_rw_level", 32'(level), 32'd15);
        checkOutput("full_rw_wr_ready_after", 32'(bus.wr_ready), 32'd1);

        // Simultaneous accepted read and write keep the level.
        nextCycle();
        applyStimulus(1'b1, 32'h2020_2020, 1'b1, 1'b1, 1'b0, 1'b1);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("rw_level", 32'(level), 32'd15);

        // Drain everything, hold out_ready one extra cycle to underrun.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (15) nextCycle();
        midCycle();
        checkOutput("drain_level", 32'(level), 32'd0);
        checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("drain_underrun_pre", 32'(underrun), 32'd0);
        checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("underrun_set", 32'(underrun), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("underrun_clr", 32'(underrun), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("underrun_set_wins", 32'(underrun), 32'd1);

        // Fall-through from an empty buffer.
        nextCycle();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1);
        midCycle();
        checkOutput("fwft_valid_pre", 32'(bus.out_valid), 32'd0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("fwft_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("fwft_data", bus.out_data, 32'hDEAD_BEEF);
        checkOutput("fwft_level", 32'(level), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("fwft_empty_level", 32'(level), 32'd0);
        checkOutput("fwft_empty_valid", 32'(bus.out_valid), 32'd0);

        // Mid-burst enable drop (3 of 8 received), then a fresh full burst.
        for (int i = 1; i <= 2; i++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h0300_0000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1);
        end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        midCycle();
        checkOutput("dis_out_valid", 32'(bus.out_valid), 32'd0);
        exp_q.delete();
        nextCycle(); idleInputs(); midCycle();
        checkOutput("dis_level", 32'(level), 32'd0);
        checkOutput("dis_req", 32'(req), 32'd0);
        checkOutput("dis_wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("dis_underrun_kept", 32'(underrun), 32'd1);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("reen_req", 32'(req), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h0400_0000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1);
            midCycle();
            checkOutput("burst2_req", 32'(req), (i == 1) ? 32'd1 : 32'd0);
        end
        nextCycle(); idleInputs(); midCycle();
        checkOutput("burst2_level", 32'(level), 32'd8);
        for (int j = 0; j < 4; j++) begin
            nextCycle();
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        nextCycle(); idleInputs(); midCycle();
        checkOutput("burst2_low_req_pending", 32'(req), 32'd0);
        nextCycle(); idleInputs(); midCycle();
        checkOutput("burst2_low_req", 32'(req), 32'd1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h0500_0000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1);
        end
        nextCycle(); idleInputs(); midCycle();
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        checkOutput("arst_wr_ready",  32'(bus.wr_ready),  32'd0);
        checkOutput("arst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("arst_out_data",  bus.out_data,       32'd0);
        checkOutput("arst_req",       32'(req),           32'd0);
        checkOutput("arst_level",     32'(level),         32'd0);
        checkOutput("arst_underrun",  32'(underrun),      32'd0);
        nextCycle();
        rst = 1'b0;
        midCycle();
        checkOutput("post_rst_req_low", 32'(req), 32'd0);
        nextCycle(); midCycle();
        checkOutput("post_rst_req", 32'(req), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
